gfx_mem_arb: RTL and testbench
==============================

GFX_MEM_ARB -- requirements
Module: gfx_mem_arb

Interface
REQ-001 Parameter OUTST_DEPTH, default 4: maximum outstanding reads (tag FIFO depth), power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 desc_req_valid / desc_req_ready  input / output  1 / 1  descriptor-fetch read handshake (requester 0).
REQ-005 desc_req_addr  input  32  descriptor read byte address.
REQ-006 desc_resp_valid / desc_resp_data  output  1 / 32  descriptor read return, single-cycle pulse, no backpressure.
REQ-007 tex_req_valid / tex_req_ready  input / output  1 / 1  texture read handshake (requester 1).
REQ-008 tex_req_addr / tex_req_rd  input  32 / 5  texture read address and destination register tag.
REQ-009 tex_resp_valid / tex_resp_data / tex_resp_rd  output  1 / 32 / 5  texture read return, single-cycle pulse, no backpressure.
REQ-010 st_valid / st_ready  input / output  1 / 1  store handshake (requester 2).
REQ-011 st_addr / st_wdata / st_wstrb  input  32 / 32 / 4  store address, data, byte strobes.
REQ-012 mem_req_valid / mem_req_ready  output / input  1 / 1  shared memory request handshake.
REQ-013 mem_req_we / mem_req_addr / mem_req_wdata / mem_req_wstrb  output  1 / 32 / 32 / 4  request fields; wdata/wstrb zero for reads.
REQ-014 mem_resp_valid / mem_resp_data  input  1 / 32  read response, in request order, no backpressure.
REQ-015 outst_count  output  $clog2(OUTST_DEPTH)+1  reads currently holding a tag.
REQ-016 err_orphan_resp  output  1  sticky: response arrived with no outstanding read.

Function
REQ-017 Output slot: one registered request; states EMPTY / HOLD; mem_req_valid = (state==HOLD).
REQ-018 HOLD: all mem_req_* fields stable until mem_req_valid && mem_req_ready.
REQ-019 Slot is "free" when EMPTY, or HOLD and mem_req_ready high this cycle.
REQ-020 Eligibility: desc/tex eligible when valid and outst_count < OUTST_DEPTH; store eligible when valid.
REQ-021 Arbitration: round-robin over 0,1,2; search starts at rr_ptr; winner granted only if slot free; rr_ptr <= winner+1 mod 3 on grant.
REQ-022 Exactly the granted requester sees ready high; ready is combinational from valids, rr_ptr, slot state, outst_count, mem_req_ready.
REQ-023 Grant at cycle N -> fields captured, mem_req_valid high at N+1; back-to-back grants allowed (1 request/cycle when mem_req_ready stays high).
REQ-024 Read grant pushes tag {src(1b: 0=desc,1=tex), rd(5b)} into tag FIFO same edge; outst_count +1.
REQ-025 Store grant pushes no tag; stores never stall on outst_count.
REQ-026 mem_resp_valid at cycle M with FIFO non-empty: pop head; at M+1 pulse desc_resp_valid or tex_resp_valid (per src) with data, tex_resp_rd = tag rd; outst_count -1.
REQ-027 Simultaneous push and pop: both take effect, outst_count unchanged; full check uses pre-pop count (pop does not free a slot same cycle).
REQ-028 mem_resp_valid with FIFO empty: response dropped, no resp pulse, err_orphan_resp set until reset.
REQ-029 FIFO pointers wrap modulo OUTST_DEPTH; count distinguishes full from empty.
REQ-030 desc_resp_valid and tex_resp_valid never high in the same cycle.

Reset
REQ-031 rst asserted: immediately state EMPTY, mem_req_valid 0, all req fields 0, FIFO empty, outst_count 0, rr_ptr 0, resp valids 0, resp data/rd 0, err_orphan_resp 0.
REQ-032 Reset mid-operation discards held request and all tags; responses arriving after reset release are orphans (REQ-028).
REQ-033 First grant after reset goes to lowest eligible index starting at 0.

Verification
REQ-034 Single read: desc_req addr 0x1000, mem_req_ready=1, memory returns 0x00002000 two cycles later -> one mem_req (we=0, addr 0x1000), desc_resp_valid pulse data 0x00002000, outst_count 0->1->0.
REQ-035 Contention: desc, tex (rd=7), store all valid continuously from reset -> mem_req order desc, tex, store, desc, ...; tex response returns rd=7.
REQ-036 Full: mem responses withheld, 4 tex reads granted -> outst_count=4, tex_req_ready 0, store still granted; one response -> count 3 next cycle, tex granted the cycle after.
REQ-037 Backpressure: mem_req_ready=0 for 5 cycles with store addr 0x2000 wdata 0xAABBCCDD wstrb 0xF -> fields stable whole time, no further grants, single accept.
REQ-038 Orphan and reset: mem_resp_valid with no outstanding read -> no resp pulse, err_orphan_resp=1; assert rst with 2 reads outstanding -> outst_count 0, err cleared, mem_req_valid 0 immediately.

Source files
------------

// File: rtl/gfx_mem_arb.sv
// Three-way round-robin arbiter (descriptor, texture, store) feeding one registered
// memory request slot, with an in-order tag FIFO that routes read data back to its requester.
module gfx_mem_arb #(
    parameter int OUTST_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         desc_req_valid,
    output logic                         desc_req_ready,
    input  logic [31:0]                  desc_req_addr,
    output logic                         desc_resp_valid,
    output logic [31:0]                  desc_resp_data,

    input  logic                         tex_req_valid,
    output logic                         tex_req_ready,
    input  logic [31:0]                  tex_req_addr,
    input  logic [4:0]                   tex_req_rd,
    output logic                         tex_resp_valid,
    output logic [31:0]                  tex_resp_data,
    output logic [4:0]                   tex_resp_rd,

    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [31:0]                  st_addr,
    input  logic [31:0]                  st_wdata,
    input  logic [3:0]                   st_wstrb,

    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_we,
    output logic [31:0]                  mem_req_addr,
    output logic [31:0]                  mem_req_wdata,
    output logic [3:0]                   mem_req_wstrb,
    input  logic                         mem_resp_valid,
    input  logic [31:0]                  mem_resp_data,

    output logic [$clog2(OUTST_DEPTH):0] outst_count,
    output logic                         err_orphan_resp
);

    localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUTST_DEPTH) + 1;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_HOLD
    } slot_state_t;

    slot_state_t        state;
    slot_state_t        state_next;

    logic [1:0]         rr_ptr;
    logic [2:0]         eligible;
    logic [1:0]         winner;
    logic               any_eligible;
    logic               slot_free;
    logic               grant;
    logic               tags_avail;

    logic [5:0]         tag_mem [OUTST_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic               orphan;
    logic [5:0]         head_tag;

    // The full check looks at the count before any same-cycle pop.
    assign tags_avail = (count < CNT_W'(OUTST_DEPTH));
    assign eligible   = {st_valid,
                         tex_req_valid  && tags_avail,
                         desc_req_valid && tags_avail};
    assign slot_free  = (state == SLOT_EMPTY) || mem_req_ready;
    assign grant      = any_eligible && slot_free;

    // Round-robin search: first eligible index at or after rr_ptr, wrapping at 3.
    always_comb begin
        logic [2:0] idx;
        winner       = 2'd0;
        any_eligible = 1'b0;
        idx          = 3'd0;
        for (int i = 0; i < 3; i++) begin
            idx = {1'b0, rr_ptr} + 3'(i);
            if (idx >= 3'd3)
                idx = idx - 3'd3;
            if (!any_eligible && eligible[idx[1:0]]) begin
                winner       = idx[1:0];
                any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        desc_req_ready = grant && (winner == 2'd0);
        tex_req_ready  = grant && (winner == 2'd1);
        st_ready       = grant && (winner == 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= SLOT_EMPTY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (grant)
            state_next = SLOT_HOLD;
        else if ((state == SLOT_HOLD) && mem_req_ready)
            state_next = SLOT_EMPTY;
    end

    always_comb begin
        mem_req_valid = (state == SLOT_HOLD);
    end

    // Request fields only change on a grant, so they stay put while the slot is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_we    <= 1'b0;
            mem_req_addr  <= 32'd0;
            mem_req_wdata <= 32'd0;
            mem_req_wstrb <= 4'd0;
            rr_ptr        <= 2'd0;
        end else if (grant) begin
            rr_ptr <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
            case (winner)
                2'd0: begin
                    mem_req_we    <= 1'b0;
                    mem_req_addr  <= desc_req_addr;
                    mem_req_wdata <= 32'd0;
                    mem_req_wstrb <= 4'd0;
                end
                2'd1: begin
                    mem_req_we    <= 1'b0;
                    mem_req_addr  <= tex_req_addr;
                    mem_req_wdata <= 32'd0;
                    mem_req_wstrb <= 4'd0;
                end
                default: begin
                    mem_req_we    <= 1'b1;
                    mem_req_addr  <= st_addr;
                    mem_req_wdata <= st_wdata;
                    mem_req_wstrb <= st_wstrb;
                end
            endcase
        end
    end

    assign push     = grant && (winner != 2'd2);
    assign pop      = mem_resp_valid && (count != '0);
    assign orphan   = mem_resp_valid && (count == '0);
    assign head_tag = tag_mem[rd_ptr];

    // Tag layout: bit 5 is the source (1 = texture), bits 4:0 the destination register.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= {winner == 2'd1, (winner == 2'd1) ? tex_req_rd : 5'd0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign outst_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_resp_valid <= 1'b0;
            desc_resp_data  <= 32'd0;
            tex_resp_valid  <= 1'b0;
            tex_resp_data   <= 32'd0;
            tex_resp_rd     <= 5'd0;
            err_orphan_resp <= 1'b0;
        end else begin
            desc_resp_valid <= pop && !head_tag[5];
            tex_resp_valid  <= pop &&  head_tag[5];
            if (pop && !head_tag[5])
                desc_resp_data <= mem_resp_data;
            if (pop && head_tag[5]) begin
                tex_resp_data <= mem_resp_data;
                tex_resp_rd   <= head_tag[4:0];
            end
            if (orphan)
                err_orphan_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gfx_mem_arb.sv
// Scoreboard bench for gfx_mem_arb: stimulus pushes expected requests/responses,
// a negedge monitor pops and compares whenever the DUT accepts a request or pulses a response.
module tb_gfx_mem_arb;

    logic        clk;
    logic        rst;
    logic        desc_req_valid, desc_req_ready, desc_resp_valid;
    logic [31:0] desc_req_addr, desc_resp_data;
    logic        tex_req_valid, tex_req_ready, tex_resp_valid;
    logic [31:0] tex_req_addr, tex_resp_data;
    logic [4:0]  tex_req_rd, tex_resp_rd;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_wdata;
    logic [3:0]  st_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [2:0]  outst_count;
    logic        err_orphan_resp;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_req_t;

    typedef struct packed {
        logic        is_tex;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_resp_t;

    exp_req_t  exp_req_q[$];
    exp_resp_t exp_resp_q[$];
    exp_req_t  mon_req;
    exp_resp_t mon_resp;

    int checks   = 0;
    int failures = 0;

    gfx_mem_arb #(.OUTST_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .desc_req_valid(desc_req_valid), .desc_req_ready(desc_req_ready),
        .desc_req_addr(desc_req_addr),
        .desc_resp_valid(desc_resp_valid), .desc_resp_data(desc_resp_data),
        .tex_req_valid(tex_req_valid), .tex_req_ready(tex_req_ready),
        .tex_req_addr(tex_req_addr), .tex_req_rd(tex_req_rd),
        .tex_resp_valid(tex_resp_valid), .tex_resp_data(tex_resp_data),
        .tex_resp_rd(tex_resp_rd),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_wdata(st_wdata), .st_wstrb(st_wstrb),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .outst_count(outst_count), .err_orphan_resp(err_orphan_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [31:0] da,
                                 input logic tv, input logic [31:0] ta, input logic [4:0] trd,
                                 input logic sv, input logic [31:0] sa, input logic [31:0] sw,
                                 input logic [3:0] ss);
        desc_req_valid = dv; desc_req_addr = da;
        tex_req_valid  = tv; tex_req_addr  = ta; tex_req_rd = trd;
        st_valid = sv; st_addr = sa; st_wdata = sw; st_wstrb = ss;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        idleInputs();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        @(negedge clk);
        checkOutput("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("rst_mem_req_addr", mem_req_addr, 32'd0);
        checkOutput("rst_outst_count", {29'd0, outst_count}, 32'd0);
        checkOutput("rst_err_orphan", {31'd0, err_orphan_resp}, 32'd0);
        checkOutput("rst_resp_valids", {30'd0, tex_resp_valid, desc_resp_valid}, 32'd0);
        step();
        rst = 1'b0;
    endtask

    function automatic exp_req_t rdReq(input logic [31:0] a);
        rdReq = '{we: 1'b0, addr: a, wdata: 32'd0, wstrb: 4'd0};
    endfunction

    // Monitor: compare every accepted request and every response pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpected_mem_req actual=0x%08h required=none", mem_req_addr);
                end else begin
                    mon_req = exp_req_q.pop_front();
                    checkOutput("mem_req_we", {31'd0, mem_req_we}, {31'd0, mon_req.we});
                    checkOutput("mem_req_addr", mem_req_addr, mon_req.addr);
                    checkOutput("mem_req_wdata", mem_req_wdata, mon_req.wdata);
                    checkOutput("mem_req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, mon_req.wstrb});
                end
            end
            if (desc_resp_valid && tex_resp_valid) begin
                checks++; failures++;
                $display("[TB] FAIL dual_resp_pulse actual=both required=one");
            end
            if (desc_resp_valid || tex_resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpected_resp actual=pulse required=none");
                end else begin
                    mon_resp = exp_resp_q.pop_front();
                    checkOutput("resp_src", {31'd0, tex_resp_valid}, {31'd0, mon_resp.is_tex});
                    if (tex_resp_valid) begin
                        checkOutput("tex_resp_data", tex_resp_data, mon_resp.data);
                        checkOutput("tex_resp_rd", {27'd0, tex_resp_rd}, {27'd0, mon_resp.rd});
                    end else begin
                        checkOutput("desc_resp_data", desc_resp_data, mon_resp.data);
                    end
                end
            end
        end
    end

    initial begin
        exp_req_t st_req;
        logic [2:0] rr_exp [6];
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

        // Single descriptor read
        resetDut();
        applyStimulus(1'b1, 32'h1000, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_req_ready = 1'b1;
        exp_req_q.push_back(rdReq(32'h1000));
        @(negedge clk);
        checkOutput("single_desc_ready", {31'd0, desc_req_ready}, 32'd1);
        checkOutput("single_count0", {29'd0, outst_count}, 32'd0);
        step();
        idleInputs();
        @(negedge clk);
        checkOutput("single_count1", {29'd0, outst_count}, 32'd1);
        step();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_2000;
        exp_resp_q.push_back('{is_tex: 1'b0, data: 32'h0000_2000, rd: 5'd0});
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checkOutput("single_count_back0", {29'd0, outst_count}, 32'd0);
        step();

        // Contention: round-robin desc, tex, store
        resetDut();
        applyStimulus(1'b1, 32'h1004, 1'b1, 32'h3000, 5'd7, 1'b1, 32'h4000, 32'h1122_3344, 4'h3);
        mem_req_ready = 1'b1;
        st_req = '{we: 1'b1, addr: 32'h4000, wdata: 32'h1122_3344, wstrb: 4'h3};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("rr_ready_onehot", {29'd0, st_ready, tex_req_ready, desc_req_ready}, {29'd0, rr_exp[i]});
            case (i % 3)
                0:       exp_req_q.push_back(rdReq(32'h1004));
                1:       exp_req_q.push_back(rdReq(32'h3000));
                default: exp_req_q.push_back(st_req);
            endcase
            step();
        end
        idleInputs();
        step();
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hA0 + 32'(k);
            exp_resp_q.push_back('{is_tex: (k % 2 == 1), data: 32'hA0 + 32'(k), rd: (k % 2 == 1) ? 5'd7 : 5'd0});
            step();
        end
        mem_resp_valid = 1'b0;
        step();
        @(negedge clk);
        checkOutput("rr_count_drained", {29'd0, outst_count}, 32'd0);
        step();

        // Full tag FIFO: texture stalls, store proceeds
        resetDut();
        applyStimulus(1'b0, 32'd0, 1'b1, 32'h5000, 5'd3, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("full_tex_ready_fill", {31'd0, tex_req_ready}, 32'd1);
            exp_req_q.push_back(rdReq(32'h5000));
            step();
        end
        @(negedge clk);
        checkOutput("full_count4", {29'd0, outst_count}, 32'd4);
        checkOutput("full_tex_ready_low", {31'd0, tex_req_ready}, 32'd0);
        step();
        st_valid = 1'b1; st_addr = 32'h6000; st_wdata = 32'hCAFE_F00D; st_wstrb = 4'hC;
        exp_req_q.push_back('{we: 1'b1, addr: 32'h6000, wdata: 32'hCAFE_F00D, wstrb: 4'hC});
        @(negedge clk);
        checkOutput("full_store_ready", {31'd0, st_ready}, 32'd1);
        checkOutput("full_tex_still_low", {31'd0, tex_req_ready}, 32'd0);
        step();
        st_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hB0;
        exp_resp_q.push_back('{is_tex: 1'b1, data: 32'hB0, rd: 5'd3});
        @(negedge clk);
        checkOutput("full_pop_same_cycle_ready", {31'd0, tex_req_ready}, 32'd0);
        step();
        mem_resp_valid = 1'b0;
        exp_req_q.push_back(rdReq(32'h5000));
        @(negedge clk);
        checkOutput("full_count3", {29'd0, outst_count}, 32'd3);
        checkOutput("full_tex_regrant", {31'd0, tex_req_ready}, 32'd1);
        step();
        tex_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("full_count_refill", {29'd0, outst_count}, 32'd4);
        step();
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hC0 + 32'(k);
            exp_resp_q.push_back('{is_tex: 1'b1, data: 32'hC0 + 32'(k), rd: 5'd3});
            step();
        end
        mem_resp_valid = 1'b0;
        step();
        @(negedge clk);
        checkOutput("full_count_drained", {29'd0, outst_count}, 32'd0);
        step();

        // Backpressure: held store stays stable, nothing else granted
        resetDut();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b1, 32'h2000, 32'hAABB_CCDD, 4'hF);
        mem_req_ready = 1'b0;
        exp_req_q.push_back('{we: 1'b1, addr: 32'h2000, wdata: 32'hAABB_CCDD, wstrb: 4'hF});
        @(negedge clk);
        checkOutput("bp_store_ready", {31'd0, st_ready}, 32'd1);
        step();
        applyStimulus(1'b1, 32'h7000, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", {31'd0, mem_req_valid}, 32'd1);
            checkOutput("bp_we", {31'd0, mem_req_we}, 32'd1);
            checkOutput("bp_addr", mem_req_addr, 32'h2000);
            checkOutput("bp_wdata", mem_req_wdata, 32'hAABB_CCDD);
            checkOutput("bp_wstrb", {28'd0, mem_req_wstrb}, 32'hF);
            checkOutput("bp_no_grant", {31'd0, desc_req_ready}, 32'd0);
            step();
        end
        mem_req_ready = 1'b1;
        exp_req_q.push_back(rdReq(32'h7000));
        @(negedge clk);
        checkOutput("bp_release_grant", {31'd0, desc_req_ready}, 32'd1);
        step();
        idleInputs();
        step();
        step();

        // Orphan response, then reset with reads outstanding
        resetDut();
        mem_resp_valid = 1'b1; mem_resp_data = 32'hEE;
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checkOutput("orphan_err_set", {31'd0, err_orphan_resp}, 32'd1);
        checkOutput("orphan_no_pulse", {30'd0, tex_resp_valid, desc_resp_valid}, 32'd0);
        step();
        applyStimulus(1'b1, 32'h8000, 1'b1, 32'h9000, 5'd9, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_req_ready = 1'b1;
        exp_req_q.push_back(rdReq(32'h8000));
        @(negedge clk);
        checkOutput("orphan_first_desc", {31'd0, desc_req_ready}, 32'd1);
        step();
        @(negedge clk);
        checkOutput("orphan_then_tex", {31'd0, tex_req_ready}, 32'd1);
        step();
        idleInputs();
        mem_req_ready = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_count2", {29'd0, outst_count}, 32'd2);
        checkOutput("pre_rst_valid", {31'd0, mem_req_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_count", {29'd0, outst_count}, 32'd0);
        checkOutput("async_rst_err", {31'd0, err_orphan_resp}, 32'd0);
        checkOutput("async_rst_valid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("async_rst_addr", mem_req_addr, 32'd0);
        step();
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_orphan", {31'd0, err_orphan_resp}, 32'd1);
        checkOutput("post_rst_no_pulse", {30'd0, tex_resp_valid, desc_resp_valid}, 32'd0);
        step();
        step();

        checkOutput("req_queue_empty", exp_req_q.size(), 32'd0);
        checkOutput("resp_queue_empty", exp_resp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
